// File: rtl/ci_pkg.sv
// Shared definitions for the ci_dispatch custom-instruction front end:
// op codes, FSM encoding and the fixed result constants.
package ci_pkg;

  typedef enum logic [1:0] {
    OP_MUL = 2'd0,
    OP_DIV = 2'd1,
    OP_RES = 2'd2,
    OP_RSV = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [31:0] DIV0_Q      = 32'hFFFF_FFFF;
  localparam logic [31:0] TIMEOUT_RES = 32'hDEAD_BEEF;

  function automatic logic [2:0] op_onehot(input op_t op);
    case (op)
      OP_MUL:  return 3'b001;
      OP_DIV:  return 3'b010;
      OP_RES:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/ci_dispatch.sv
// Nios II custom-instruction dispatcher: latches a request, starts one unit, returns its result.
// Optional WAIT-state abort counter enabled with `define CI_TIMEOUT_EN.
module ci_dispatch
  import ci_pkg::*;
#(
  parameter int W       = 32,
  parameter int TIMEOUT = 128
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clk_en,
  input  logic         start,
  input  logic [1:0]   n,
  input  logic [W-1:0] dataa,
  input  logic [W-1:0] datab,
  output logic [W-1:0] result,
  output logic         done,
  output logic         err,
  output logic [W-1:0] u_dataa,
  output logic [W-1:0] u_datab,
  output logic [2:0]   u_start,
  input  logic [2:0]   u_done,
  input  logic [W-1:0] u_res0,
  input  logic [W-1:0] u_res1,
  input  logic [W-1:0] u_res2
);

  state_t       state, state_nx;
  op_t          sel, sel_nx;
  logic [W-1:0] result_nx, a_nx, b_nx;
  logic         done_nx, err_nx;
  logic [2:0]   u_start_nx;
  logic         sel_done;
  logic [W-1:0] sel_res;

`ifdef CI_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt, wait_cnt_nx;
`endif

  // Only the selected unit's handshake is visible; reserved ops select nothing.
  always_comb begin
    sel_done = 1'b0;
    sel_res  = '0;
    case (sel)
      OP_MUL: begin sel_done = u_done[0]; sel_res = u_res0; end
      OP_DIV: begin sel_done = u_done[1]; sel_res = u_res1; end
      OP_RES: begin sel_done = u_done[2]; sel_res = u_res2; end
      default: ;
    endcase
  end

  always_comb begin
    state_nx   = state;
    sel_nx     = sel;
    a_nx       = u_dataa;
    b_nx       = u_datab;
    result_nx  = result;
    err_nx     = err;
    done_nx    = 1'b0;
    u_start_nx = 3'b000;
`ifdef CI_TIMEOUT_EN
    wait_cnt_nx = wait_cnt;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          sel_nx = op_t'(n);
          a_nx   = dataa;
          b_nx   = datab;
          err_nx = 1'b0;
          if (op_t'(n) == OP_RSV) begin
            result_nx = '0;
            err_nx    = 1'b1;
            done_nx   = 1'b1;
            state_nx  = S_DONE;
          end else if (op_t'(n) != OP_MUL && datab == '0) begin
            // Division by zero never reaches the units; answer is fixed here.
            result_nx = (op_t'(n) == OP_DIV) ? W'(DIV0_Q) : dataa;
            done_nx   = 1'b1;
            state_nx  = S_DONE;
          end else begin
            u_start_nx = op_onehot(op_t'(n));
            state_nx   = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        state_nx = S_WAIT;
`ifdef CI_TIMEOUT_EN
        wait_cnt_nx = '0;
`endif
      end
      S_WAIT: begin
        if (sel_done) begin
          result_nx = sel_res;
          done_nx   = 1'b1;
          state_nx  = S_DONE;
        end
`ifdef CI_TIMEOUT_EN
        else if (wait_cnt == CW'(TIMEOUT - 1)) begin
          result_nx = W'(TIMEOUT_RES);
          err_nx    = 1'b1;
          done_nx   = 1'b1;
          state_nx  = S_DONE;
        end else begin
          wait_cnt_nx = wait_cnt + CW'(1);
        end
`endif
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      sel     <= OP_MUL;
      u_dataa <= '0;
      u_datab <= '0;
      result  <= '0;
      err     <= 1'b0;
      done    <= 1'b0;
      u_start <= 3'b000;
`ifdef CI_TIMEOUT_EN
      wait_cnt <= '0;
`endif
    end else if (clk_en) begin
      state   <= state_nx;
      sel     <= sel_nx;
      u_dataa <= a_nx;
      u_datab <= b_nx;
      result  <= result_nx;
      err     <= err_nx;
      done    <= done_nx;
      u_start <= u_start_nx;
`ifdef CI_TIMEOUT_EN
      wait_cnt <= wait_cnt_nx;
`endif
    end
  end

endmodule

// File: tb/tb_ci_dispatch.sv
// Self-checking bench for ci_dispatch: transaction-level timing model (in enabled-clock
// units) compared every cycle, plus directed pins and randomized traffic.
module tb_ci_dispatch;
  import ci_pkg::*;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_en = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  n = 2'd0;
  logic [31:0] dataa = '0, datab = '0;
  logic [31:0] result, u_dataa, u_datab;
  logic        done, err;
  logic [2:0]  u_start;
  logic [2:0]  u_done = 3'b000;
  logic [31:0] u_res0 = '0, u_res1 = '0, u_res2 = '0;

  always #5 clk = ~clk;

  ci_dispatch #(.W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .n(n),
    .dataa(dataa), .datab(datab), .result(result), .done(done), .err(err),
    .u_dataa(u_dataa), .u_datab(u_datab), .u_start(u_start), .u_done(u_done),
    .u_res0(u_res0), .u_res1(u_res1), .u_res2(u_res2)
  );

  int tests = 0, fails = 0;
  int ecyc = 0;
  int accE = 0, usCyc = -1, doneCyc = -1, pulseCyc = -1, spurCyc = -1;
  int doneSeen = -100;
  logic [2:0]  usVal = '0, pulseVal = '0, spurVal = '0, eus;
  logic [31:0] newA = '0, oldA = '0, newB = '0, oldB = '0;
  logic [31:0] expRes = '0, prevRes = '0;
  logic        expErr = 1'b0, prevErr = 1'b0;
  bit          chkEn = 1'b0;

  // Enabled-edge counter: all model times are expressed in these units.
  always @(posedge clk) if (!reset && clk_en) ecyc <= ecyc + 1;

  always @(posedge clk) begin
    #1;
    u_done = ((ecyc == pulseCyc) ? pulseVal : 3'b000) | ((ecyc == spurCyc) ? spurVal : 3'b000);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h (ecyc %0d, t=%0t)", name, act, exp, ecyc, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chkEn) begin
      eus = (ecyc == usCyc) ? usVal : 3'b000;
      checkOutput("u_start", {29'b0, u_start}, {29'b0, eus});
      checkOutput("done", {31'b0, done}, {31'b0, (ecyc == doneCyc)});
      if (done) doneSeen = ecyc;
      if (ecyc == doneCyc) begin
        checkOutput("result_at_done", result, expRes);
        checkOutput("err_at_done", {31'b0, err}, {31'b0, expErr});
      end else if (ecyc < accE) begin
        checkOutput("result_held_prev", result, prevRes);
        checkOutput("err_held_prev", {31'b0, err}, {31'b0, prevErr});
      end else if (ecyc > doneCyc) begin
        checkOutput("result_held", result, expRes);
        checkOutput("err_held", {31'b0, err}, {31'b0, expErr});
      end else begin
        checkOutput("err_busy", {31'b0, err}, 32'd0);
      end
      checkOutput("u_dataa", u_dataa, (ecyc >= accE) ? newA : oldA);
      checkOutput("u_datab", u_datab, (ecyc >= accE) ? newB : oldB);
    end
  end

  function automatic logic [31:0] unitResult(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'd0:    return a * b;
      2'd1:    return a / b;
      default: return a % b;
    endcase
  endfunction

  // Presents one request and records what the block must do with it.
  task automatic issueReq(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input bit noisy);
    int e;
    logic [2:0] oh;
    logic [31:0] r;
    bit timedOut;
    @(posedge clk); #1;
    e = ecyc + 1;
    oh = 3'b001 << op;
    oldA = newA; oldB = newB; newA = a; newB = b;
    prevRes = expRes; prevErr = expErr; accE = e;
    pulseCyc = -1; spurCyc = -1; usCyc = -1;
    u_res0 = $urandom; u_res1 = $urandom; u_res2 = $urandom;
    if (op == 2'd3) begin
      doneCyc = e; expRes = 32'd0; expErr = 1'b1;
    end else if (op != 2'd0 && b == 32'd0) begin
      doneCyc = e; expRes = (op == 2'd1) ? 32'hFFFF_FFFF : a; expErr = 1'b0;
    end else begin
      r = unitResult(op, a, b);
      usCyc = e; usVal = oh;
      case (op)
        2'd0:    u_res0 = r;
        2'd1:    u_res1 = r;
        default: u_res2 = r;
      endcase
      timedOut = 1'b0;
`ifdef CI_TIMEOUT_EN
      timedOut = (lat > TMO);
`endif
      if (timedOut) begin
        doneCyc = e + TMO + 1; expRes = 32'hDEAD_BEEF; expErr = 1'b1;
      end else begin
        pulseCyc = e + lat; pulseVal = oh; doneCyc = e + lat + 1; expRes = r; expErr = 1'b0;
      end
      if (noisy) begin
        if ($urandom % 2 == 0) begin
          spurCyc = e; spurVal = oh;
        end else begin
          spurCyc = e + 1 + int'($urandom_range(0, lat - 1));
          spurVal = ~oh & 3'($urandom_range(1, 7));
        end
      end
    end
    clk_en = 1'b1; start = 1'b1; n = op; dataa = a; datab = b;
  endtask

  task automatic waitDone(input bit noisy);
    bit fin = 1'b0;
    for (int i = 0; i < 500 && !fin; i++) begin
      @(posedge clk); #1;
      if (ecyc > doneCyc) fin = 1'b1;
      else if (noisy) begin
        clk_en = ($urandom % 4 != 0);
        start  = ($urandom % 3 == 0);
        n      = 2'($urandom);
        dataa  = $urandom;
        datab  = $urandom;
      end else start = 1'b0;
    end
    start = 1'b0; clk_en = 1'b1;
    if (!fin) begin
      tests++; fails++;
      $display("[TB] FAIL txn_bound: ecyc %0d, done required at %0d", ecyc, doneCyc);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input int lat, input bit noisy);
    issueReq(op, a, b, lat, noisy);
    waitDone(noisy);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_result"}, result, 32'd0);
    checkOutput({tag, "_done"}, {31'b0, done}, 32'd0);
    checkOutput({tag, "_err"}, {31'b0, err}, 32'd0);
    checkOutput({tag, "_u_start"}, {29'b0, u_start}, 32'd0);
    checkOutput({tag, "_u_dataa"}, u_dataa, 32'd0);
    checkOutput({tag, "_u_datab"}, u_datab, 32'd0);
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    reset = 1'b0; clk_en = 1'b1; chkEn = 1'b1;

    applyStimulus(2'd0, 32'd7, 32'd6, 10, 1'b0);
    checkOutput("pin_mul_res", result, 32'd42);
    checkOutput("pin_mul_err", {31'b0, err}, 32'd0);
    checkOutput("pin_mul_lat", doneSeen - accE + 1, 32'd12);

    applyStimulus(2'd1, 32'd100, 32'd0, 1, 1'b0);
    checkOutput("pin_div0_res", result, 32'hFFFF_FFFF);
    checkOutput("pin_div0_lat", doneSeen - accE + 1, 32'd1);
    applyStimulus(2'd2, 32'd100, 32'd0, 1, 1'b0);
    checkOutput("pin_rem0_res", result, 32'd100);
    checkOutput("pin_rem0_lat", doneSeen - accE + 1, 32'd1);

    issueReq(2'd2, 32'd17, 32'd5, 5, 1'b0);
    spurCyc = accE + 2; spurVal = 3'b001;
    waitDone(1'b0);
    checkOutput("pin_rem_res", result, 32'd2);

    // Reset three cycles into WAIT; the unit's late answer must be dropped.
    issueReq(2'd1, 32'd50, 32'd7, 10, 1'b0);
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 50 && ecyc < accE + 4; i++) begin @(posedge clk); #1; end
    reset = 1'b1; chkEn = 1'b0;
    usCyc = -1; doneCyc = -1; accE = 0;
    newA = '0; oldA = '0; newB = '0; oldB = '0;
    expRes = '0; expErr = 1'b0; prevRes = '0; prevErr = 1'b0;
    #1;
    checkResetOutputs("midreset");
    @(posedge clk); #1; reset = 1'b0; chkEn = 1'b1;
    repeat (12) @(posedge clk);
    applyStimulus(2'd1, 32'd50, 32'd7, 3, 1'b0);
    checkOutput("pin_after_reset_res", result, 32'd7);

    issueReq(2'd0, 32'd3, 32'd5, 4, 1'b0);
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 50 && ecyc < pulseCyc; i++) begin @(posedge clk); #1; end
    clk_en = 1'b0; start = 1'b1; n = 2'd2; dataa = 32'd9; datab = 32'd4;
    repeat (5) @(posedge clk);
    #1;
    start = 1'b0; clk_en = 1'b1;
    waitDone(1'b0);
    checkOutput("pin_clken_res", result, 32'd15);
    checkOutput("pin_clken_lat", doneSeen - accE + 1, 32'd6);

    applyStimulus(2'd3, 32'd5, 32'd6, 1, 1'b0);
    checkOutput("pin_rsv_res", result, 32'd0);
    checkOutput("pin_rsv_err", {31'b0, err}, 32'd1);
    checkOutput("pin_rsv_lat", doneSeen - accE + 1, 32'd1);

`ifdef CI_TIMEOUT_EN
    applyStimulus(2'd0, 32'd1, 32'd2, 100, 1'b0);
    checkOutput("pin_tmo_res", result, 32'hDEAD_BEEF);
    checkOutput("pin_tmo_err", {31'b0, err}, 32'd1);
    checkOutput("pin_tmo_lat", doneSeen - accE + 1, TMO + 2);
`endif

    for (int t = 0; t < 150; t++) begin
      op = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
      a  = ($urandom % 2 == 0) ? $urandom : 32'($urandom_range(0, 5000));
      if ($urandom % 6 == 0) b = 32'd0;
      else b = ($urandom % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
      applyStimulus(op, a, b, int'($urandom_range(1, 12)), 1'b1);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, %0d failed so far", fails);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
